// File: rtl/shake128_absorb_arbiter_pkg.sv
// rtl/shake128_absorb_arbiter_pkg.sv - shared constants and FSM encoding for the absorb arbiter
package shake128_absorb_arbiter_pkg;

    localparam int SHAKE128_RATE = 168;
    localparam int STATE_W       = 1600;
    localparam int POS_W         = 32;
    localparam int INLEN_W       = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin picker; prio names the requester that wins a tie
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !prio)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/shake128_absorb_arbiter.sv
// rtl/shake128_absorb_arbiter.sv - shares one external SHAKE128 absorb unit between two requesters
module shake128_absorb_arbiter
    import shake128_absorb_arbiter_pkg::*;
#(
    parameter int IN_LEN  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_rtr,
    input  logic [STATE_W-1:0]    req0_state_in,
    input  logic [POS_W-1:0]      req0_pos_in,
    input  logic [IN_LEN*8-1:0]   req0_data,
    input  logic [INLEN_W-1:0]    req0_inlen,
    output logic [STATE_W-1:0]    req0_state_out,
    output logic [POS_W-1:0]      req0_pos_out,
    output logic                  req0_rts,
    input  logic                  req1_rtr,
    input  logic [STATE_W-1:0]    req1_state_in,
    input  logic [POS_W-1:0]      req1_pos_in,
    input  logic [IN_LEN*8-1:0]   req1_data,
    input  logic [INLEN_W-1:0]    req1_inlen,
    output logic [STATE_W-1:0]    req1_state_out,
    output logic [POS_W-1:0]      req1_pos_out,
    output logic                  req1_rts,
    output logic                  abs_rtr,
    output logic [STATE_W-1:0]    abs_state_in,
    output logic [POS_W-1:0]      abs_pos_in,
    output logic [IN_LEN*8-1:0]   abs_data,
    output logic [INLEN_W-1:0]    abs_inlen,
    input  logic [STATE_W-1:0]    abs_state_out,
    input  logic [POS_W-1:0]      abs_pos_out,
    input  logic                  abs_rts,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  err
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               prio_q;
    logic [1:0]         pick;
    logic               do_grant;
    logic               do_done;
    logic               do_timeout;
    logic               finish;
    logic [STATE_W-1:0] res_state;
    logic [POS_W-1:0]   res_pos;

    rr_arbiter2 u_rr (
        .req  ({req1_rtr, req0_rtr}),
        .prio (prio_q),
        .gnt  (pick)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // cnt_q counts cycles since the request was seen, so the timeout lands after TIMEOUT-1 of them
    always_comb begin
        state_d    = state_q;
        do_grant   = 1'b0;
        do_done    = 1'b0;
        do_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pick) begin
                    do_grant = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (abs_rts) begin
                    do_done = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    do_timeout = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign finish    = do_done | do_timeout;
    assign res_state = do_done ? abs_state_out : abs_state_in;
    assign res_pos   = do_done ? abs_pos_out : abs_pos_in;

    always_ff @(posedge clock) begin
        if (!reset) begin
            abs_rtr        <= 1'b0;
            abs_state_in   <= '0;
            abs_pos_in     <= '0;
            abs_data       <= '0;
            abs_inlen      <= '0;
            req0_state_out <= '0;
            req0_pos_out   <= '0;
            req0_rts       <= 1'b0;
            req1_state_out <= '0;
            req1_pos_out   <= '0;
            req1_rts       <= 1'b0;
            grant          <= 2'b00;
            busy           <= 1'b0;
            err            <= 1'b0;
            cnt_q          <= '0;
            prio_q         <= 1'b0;
        end else begin
            req0_rts <= 1'b0;
            req1_rts <= 1'b0;
            if (do_grant) begin
                grant   <= pick;
                busy    <= 1'b1;
                abs_rtr <= 1'b1;
                cnt_q   <= CNT_W'(1);
                if (pick[1]) begin
                    abs_state_in <= req1_state_in;
                    abs_pos_in   <= req1_pos_in;
                    abs_data     <= req1_data;
                    abs_inlen    <= req1_inlen;
                end else begin
                    abs_state_in <= req0_state_in;
                    abs_pos_in   <= req0_pos_in;
                    abs_data     <= req0_data;
                    abs_inlen    <= req0_inlen;
                end
            end
            if (state_q == ST_BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (finish) begin
                abs_rtr <= 1'b0;
                if (grant[0]) begin
                    req0_rts       <= 1'b1;
                    req0_state_out <= res_state;
                    req0_pos_out   <= res_pos;
                end
                if (grant[1]) begin
                    req1_rts       <= 1'b1;
                    req1_state_out <= res_state;
                    req1_pos_out   <= res_pos;
                end
            end
            if (do_timeout) begin
                err <= 1'b1;
            end
            // the requester just served loses the next tie
            if (state_q == ST_RESP) begin
                grant  <= 2'b00;
                busy   <= 1'b0;
                cnt_q  <= '0;
                prio_q <= grant[0];
            end
        end
    end

endmodule

// File: tb/tb_shake128_absorb_arbiter.sv
// tb/tb_shake128_absorb_arbiter.sv - randomized and directed bench against a transaction-level model
module tb_shake128_absorb_arbiter;

    localparam int IN_LEN  = 32;
    localparam int TIMEOUT = 8;
    localparam int DW      = IN_LEN * 8;
    localparam int W       = 1600;

    logic            clock = 1'b0;
    logic            reset;
    logic            rtr [2];
    logic [W-1:0]    st_in [2];
    logic [31:0]     pos_in [2];
    logic [DW-1:0]   data [2];
    logic [63:0]     inlen [2];
    logic [W-1:0]    st_out [2];
    logic [31:0]     pos_out [2];
    logic            rts [2];
    logic            abs_rtr;
    logic [W-1:0]    abs_st_in;
    logic [31:0]     abs_pos_in;
    logic [DW-1:0]   abs_data;
    logic [63:0]     abs_inlen;
    logic [W-1:0]    abs_st_out;
    logic [31:0]     abs_pos_out;
    logic            abs_rts;
    logic [1:0]      grant;
    logic            busy;
    logic            err;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    always #5 clock = ~clock;

    shake128_absorb_arbiter #(.IN_LEN(IN_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clock          (clock),
        .reset          (reset),
        .req0_rtr       (rtr[0]),
        .req0_state_in  (st_in[0]),
        .req0_pos_in    (pos_in[0]),
        .req0_data      (data[0]),
        .req0_inlen     (inlen[0]),
        .req0_state_out (st_out[0]),
        .req0_pos_out   (pos_out[0]),
        .req0_rts       (rts[0]),
        .req1_rtr       (rtr[1]),
        .req1_state_in  (st_in[1]),
        .req1_pos_in    (pos_in[1]),
        .req1_data      (data[1]),
        .req1_inlen     (inlen[1]),
        .req1_state_out (st_out[1]),
        .req1_pos_out   (pos_out[1]),
        .req1_rts       (rts[1]),
        .abs_rtr        (abs_rtr),
        .abs_state_in   (abs_st_in),
        .abs_pos_in     (abs_pos_in),
        .abs_data       (abs_data),
        .abs_inlen      (abs_inlen),
        .abs_state_out  (abs_st_out),
        .abs_pos_out    (abs_pos_out),
        .abs_rts        (abs_rts),
        .grant          (grant),
        .busy           (busy),
        .err            (err)
    );

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (low 64 bits)", name, got[63:0], exp[63:0]);
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic new_ops(input int n);
        logic [W-1:0] t;
        t        = rand_wide();
        st_in[n] = rand_wide();
        pos_in[n] = 32'($urandom_range(167));
        data[n]  = t[DW-1:0];
        inlen[n] = 64'($urandom_range(IN_LEN));
        rtr[n]   = 1'b1;
    endtask

    // Model: who owns the unit, how long it has waited, and what each requester was last handed.
    int           m_own;
    bit           m_resp;
    int           m_age;
    int           m_prio;
    bit           m_err;
    logic [1:0]   m_rts;
    logic [W-1:0] m_sout [2];
    logic [31:0]  m_pout [2];
    logic [W-1:0] m_ast;
    logic [31:0]  m_apos;
    logic [DW-1:0] m_adata;
    logic [63:0]  m_ainl;

    initial forever begin
        @(posedge clock);
        if (!reset) begin
            m_own = -1; m_resp = 1'b0; m_age = 0; m_prio = 0; m_err = 1'b0; m_rts = 2'b00;
            m_sout[0] = '0; m_sout[1] = '0; m_pout[0] = '0; m_pout[1] = '0;
            m_ast = '0; m_apos = '0; m_adata = '0; m_ainl = '0;
        end else if (m_resp) begin
            m_rts  = 2'b00;
            m_prio = 1 - m_own;
            m_own  = -1;
            m_resp = 1'b0;
        end else if (m_own >= 0) begin
            if (abs_rts || m_age == TIMEOUT - 1) begin
                m_sout[m_own] = abs_rts ? abs_st_out : m_ast;
                m_pout[m_own] = abs_rts ? abs_pos_out : m_apos;
                if (!abs_rts) m_err = 1'b1;
                m_rts[m_own] = 1'b1;
                m_resp = 1'b1;
            end else begin
                m_age++;
            end
        end else if (rtr[0] || rtr[1]) begin
            m_own   = (rtr[0] && rtr[1]) ? m_prio : (rtr[0] ? 0 : 1);
            m_ast   = st_in[m_own];
            m_apos  = pos_in[m_own];
            m_adata = data[m_own];
            m_ainl  = inlen[m_own];
            m_age   = 1;
        end
    end

    initial forever begin
        @(negedge clock);
        if (check_en) begin
            logic [1:0] eg;
            eg = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
            chk("grant", W'(grant), W'(eg));
            chk("busy", W'(busy), W'(m_own >= 0));
            chk("err", W'(err), W'(m_err));
            chk("abs_rtr", W'(abs_rtr), W'(m_own >= 0 && !m_resp));
            chk("abs_state_in", abs_st_in, m_ast);
            chk("abs_pos_in", W'(abs_pos_in), W'(m_apos));
            chk("abs_data", W'(abs_data), W'(m_adata));
            chk("abs_inlen", W'(abs_inlen), W'(m_ainl));
            for (int n = 0; n < 2; n++) begin
                chk($sformatf("req%0d_rts", n), W'(rts[n]), W'(m_rts[n]));
                chk($sformatf("req%0d_state_out", n), st_out[n], m_sout[n]);
                chk($sformatf("req%0d_pos_out", n), W'(pos_out[n]), W'(m_pout[n]));
            end
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0; rtr[0] = 1'b0; rtr[1] = 1'b0; abs_rts = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    // Starts in the IDLE cycle with requests raised; returns in the next IDLE cycle.
    task automatic serve(input int lat, input int own, input bit rereq);
        for (int c = 1; c <= lat + 2; c++) begin
            @(posedge clock); #1;
            abs_rts = 1'b0;
            if (c == lat) begin
                abs_rts = 1'b1; abs_st_out = rand_wide(); abs_pos_out = $urandom;
            end
            if (c == 1) chk("srv_grant", W'(grant), W'((own == 0) ? 2'b01 : 2'b10));
            if (c == lat + 1) begin
                chk("srv_rts", W'(rts[own]), W'(1'b1));
                chk("srv_state_out", st_out[own], abs_st_out);
            end
            if (c == lat + 2) begin
                chk("srv_idle_busy", W'(busy), W'(1'b0));
                chk("srv_idle_grant", W'(grant), W'(2'b00));
                if (rereq) new_ops(own);
                else rtr[own] = 1'b0;
            end
        end
    endtask

    int lat;
    bit seen;
    bit drop [2];

    initial begin
        reset = 1'b0; abs_rts = 1'b0; abs_st_out = '0; abs_pos_out = '0;
        for (int n = 0; n < 2; n++) begin
            rtr[n] = 1'b0; st_in[n] = '0; pos_in[n] = '0; data[n] = '0; inlen[n] = '0;
        end
        repeat (2) @(posedge clock);
        #1;
        check_en = 1'b1;
        chk("rst_grant", W'(grant), W'(2'b00));
        chk("rst_busy", W'(busy), W'(1'b0));
        chk("rst_err", W'(err), W'(1'b0));
        chk("rst_abs_rtr", W'(abs_rtr), W'(1'b0));
        chk("rst_pos_out1", W'(pos_out[1]), W'(32'd0));
        reset = 1'b1;

        // single request: pos 0 + 32 bytes, done pulse in cycle 5
        new_ops(0); pos_in[0] = 32'd0; inlen[0] = 64'd32;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clock); #1;
            abs_rts = (c == 5);
            if (c == 5) begin abs_pos_out = 32'd32; abs_st_out = rand_wide(); end
            if (c <= 5) begin
                chk("t1_grant", W'(grant), W'(2'b01));
                chk("t1_rts_early", W'(rts[0]), W'(1'b0));
            end
            if (c == 6) begin
                chk("t1_rts", W'(rts[0]), W'(1'b1));
                chk("t1_pos_out", W'(pos_out[0]), W'(32'd32));
            end
            if (c == 7) begin
                chk("t1_rts_once", W'(rts[0]), W'(1'b0));
                rtr[0] = 1'b0;
            end
        end

        // simultaneous pair after reset, then strict alternation while both keep asking
        do_reset();
        new_ops(0); new_ops(1);
        serve(3, 0, 1'b1);
        serve(2, 1, 1'b1);
        serve(1, 0, 1'b1);
        serve(4, 1, 1'b0);
        serve(2, 0, 1'b0);

        // timeout: no done pulse, err in cycle 8 and the operands come back untouched
        do_reset();
        new_ops(0);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock); #1;
            if (c == 7) chk("to_err_early", W'(err), W'(1'b0));
            if (c == 8) begin
                chk("to_err", W'(err), W'(1'b1));
                chk("to_rts", W'(rts[0]), W'(1'b1));
                chk("to_state_out", st_out[0], st_in[0]);
                chk("to_pos_out", W'(pos_out[0]), W'(pos_in[0]));
            end
            if (c == 9) rtr[0] = 1'b0;
            if (c == 12) chk("to_err_sticky", W'(err), W'(1'b1));
        end

        // reset in BUSY cycle 3, then a stray done pulse while idle
        new_ops(1);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clock); #1;
            abs_rts = 1'b0;
            if (c == 3) reset = 1'b0;
            if (c == 4) begin
                chk("rb_zero", W'({grant, busy, err, abs_rtr, rts[0], rts[1]}), W'(7'd0));
                chk("rb_state_out1", st_out[1], '0);
                chk("rb_abs_state", abs_st_in, '0);
                reset = 1'b1; rtr[1] = 1'b0; abs_rts = 1'b1;
            end
            if (c >= 5) chk("rb_no_resp", W'({rts[0], rts[1], busy}), W'(3'd0));
        end

        seen = 1'b0; lat = 0; drop[0] = 1'b0; drop[1] = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clock); #1;
            reset = ($urandom_range(299) != 0);
            abs_rts = 1'b0;
            if (abs_rtr) begin
                if (!seen) begin
                    seen = 1'b1;
                    lat = ($urandom_range(19) == 0) ? 99 : $urandom_range(6);
                end
                if (lat == 0) begin
                    abs_rts = 1'b1; abs_st_out = rand_wide(); abs_pos_out = $urandom;
                end else begin
                    lat--;
                end
            end else begin
                seen = 1'b0;
                if ($urandom_range(15) == 0) begin
                    abs_rts = 1'b1; abs_st_out = rand_wide(); abs_pos_out = $urandom;
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (drop[n]) begin
                    drop[n] = 1'b0;
                    if ($urandom_range(1) == 1) new_ops(n);
                    else rtr[n] = 1'b0;
                end else if (!rtr[n] && $urandom_range(3) == 0) begin
                    new_ops(n);
                end
                if (rts[n]) drop[n] = 1'b1;
            end
        end

        rtr[0] = 1'b0; rtr[1] = 1'b0; abs_rts = 1'b0; reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
